// File: rtl/fp_cvt_sd_seq.sv
// ---------------------------------------------------------------------------
// fp_cvt_sd_seq
//   IEEE-754 binary32 -> binary64 widening converter. Every binary32 value is
//   exactly representable in binary64, so there is no rounding logic.
//   Single-precision subnormals are normalised by a 1-bit-per-cycle shifter,
//   so the latency depends on the data. All other inputs take one cycle.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
//   are both high. The producer holds its payload stable until that edge. The
//   consumer may change ready at any time. in_ready depends combinationally on
//   out_ready, so a finished result can drain and a new operand can enter on
//   the same edge.
//
// Parameters
//   CANON_NAN     1: every NaN result is 64'h7FF8000000000000.
//                 0: keep the sign, force the quiet bit, carry s[21:0] through.
//   FLUSH_SUBNORM 1: a subnormal input gives a signed zero after one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   s is valid
//   in_ready   out  converter can accept an input this cycle
//   s          in   binary32 operand
//   out_valid  out  d and nv are valid
//   out_ready  in   downstream accepts d this cycle
//   d          out  binary64 result
//   nv         out  invalid flag (input was a signalling NaN)
//   busy       out  high while normalising a subnormal
// ---------------------------------------------------------------------------
module fp_cvt_sd_seq #(
  parameter bit CANON_NAN     = 1'b1,
  parameter bit FLUSH_SUBNORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] d,
  output logic        nv,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [22:0] mant;    // subnormal fraction being shifted up
  logic [4:0]  k;       // number of shifts performed so far
  logic        sg_r;    // sign of the subnormal being normalised

  logic        sg;
  logic [7:0]  es;
  logic [22:0] fs;
  logic        accept;
  logic        is_sub;
  logic [63:0] dec_d;
  logic        dec_nv;
  logic [23:0] mant_sh;
  logic [4:0]  k_inc;
  logic [10:0] norm_exp;

  assign sg = s[31];
  assign es = s[30:23];
  assign fs = s[22:0];

  assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_sub    = (es == 8'h00) && (fs != 23'd0);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_NORM);

  // Single-cycle decode of everything except a subnormal that needs
  // normalising. A flushed subnormal falls into the signed-zero branch.
  always_comb begin
    dec_d  = 64'd0;
    dec_nv = 1'b0;
    if (es == 8'hFF) begin
      if (fs == 23'd0) begin
        dec_d = {sg, 11'h7FF, 52'd0};
      end else begin
        // Signalling NaN has the quiet bit (fs[22]) clear.
        dec_nv = ~fs[22];
        if (CANON_NAN) dec_d = 64'h7FF8000000000000;
        else           dec_d = {sg, 11'h7FF, 1'b1, fs[21:0], 29'd0};
      end
    end else if (es == 8'h00) begin
      dec_d = {sg, 63'd0};
    end else begin
      // Rebias 127 -> 1023; the 11-bit sum cannot overflow.
      dec_d = {sg, {3'd0, es} + 11'd896, fs, 29'd0};
    end
  end

  // One normalisation step. Bit 23 of the shifted value is the hidden bit;
  // once it is set, k shifts were needed and the exponent is 897 - k.
  assign mant_sh  = {mant, 1'b0};
  assign k_inc    = k + 5'd1;
  assign norm_exp = 11'd897 - {6'd0, k_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      d     <= 64'd0;
      nv    <= 1'b0;
      mant  <= 23'd0;
      k     <= 5'd0;
      sg_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_sub && !FLUSH_SUBNORM) begin
              mant  <= fs;
              k     <= 5'd0;
              sg_r  <= sg;
              state <= ST_NORM;
            end else begin
              d     <= dec_d;
              nv    <= dec_nv;
              state <= ST_DONE;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_NORM: begin
          mant <= mant_sh[22:0];
          k    <= k_inc;
          if (mant_sh[23]) begin
            d     <= {sg_r, norm_exp, mant_sh[22:0], 29'd0};
            nv    <= 1'b0;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cvt_sd_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_cvt_sd_seq
//   Bench for fp_cvt_sd_seq. Two instances share the input and output
//   handshake: dut uses canonical NaNs, dut_raw propagates NaN payloads.
//   Expected results are queued at input accept and popped by a monitor on
//   every output handshake. The reference model works from the numeric value
//   m * 2^e of the binary32 operand rather than from field manipulation.
// ---------------------------------------------------------------------------
module tb_fp_cvt_sd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] s = 32'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, nv, busy;
  logic [63:0] d;
  logic        in_ready2, out_valid2, nv2, busy2;
  logic [63:0] d2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rdy_mode = 1;          // 0: out_ready low, 1: high, 2: random

  logic [128:0] exp_q[$];    // {d canonical, d raw, nv}
  int           hs_cyc[$];   // cycle numbers of output handshakes

  fp_cvt_sd_seq #(.CANON_NAN(1'b1), .FLUSH_SUBNORM(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .nv(nv), .busy(busy)
  );

  fp_cvt_sd_seq #(.CANON_NAN(1'b0), .FLUSH_SUBNORM(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .s(s),
    .out_valid(out_valid2), .out_ready(out_ready), .d(d2), .nv(nv2), .busy(busy2)
  );

  // ---------------- clock / reset-independent drivers ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [31:0] x, input bit canon);
    logic        sg;
    int          es, e, p, ex;
    logic [23:0] m;
    logic [63:0] frac;
    sg = x[31];
    es = int'(x[30:23]);
    if (es == 255) begin
      if (x[22:0] == 23'd0) return {sg, 11'h7FF, 52'd0};
      if (canon) return 64'h7FF8000000000000;
      return {sg, 11'h7FF, 1'b1, x[21:0], 29'd0};
    end
    if (es == 0 && x[22:0] == 23'd0) return {sg, 63'd0};
    // value = m * 2^e
    if (es == 0) begin
      m = {1'b0, x[22:0]};
      e = -149;
    end else begin
      m = {1'b1, x[22:0]};
      e = es - 150;
    end
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    ex   = e + p + 1023;
    frac = (64'(m) - (64'd1 << p)) << (52 - p);
    return {sg, ex[10:0], frac[51:0]};
  endfunction

  function automatic logic model_nv(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0) && !x[22];
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left 1ns after a rising edge.
  task automatic send_exp(input logic [31:0] val, input logic [63:0] ed,
                          input logic [63:0] edr, input logic en);
    int n;
    n = 0;
    s = val;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL accept_timeout: in_ready stuck low for s=%h", val);
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back({ed, edr, en});
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] val);
    send_exp(val, model(val, 1'b1), model(val, 1'b0), model_nv(val));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_output: d=%h with empty queue", d);
      end else begin
        logic [128:0] e;
        e = exp_q.pop_front();
        chk("d", d, e[128:65]);
        chk("nv", 64'(nv), 64'(e[0]));
        chk("d_raw", d2, e[64:1]);
        chk("nv_raw", 64'(nv2), 64'(e[0]));
        chk("valid_raw", 64'(out_valid2), 64'd1);
        chk("ready_raw_done", 64'(in_ready2 | busy2), 64'd1);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int nb;
    int first_acc;
    logic [31:0] x;

    // reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", d, 64'd0);
    chk("rst_nv", 64'(nv), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1-cycle latency
    send_exp(32'h3F800000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    @(negedge clk);
    chk("lat1_valid", 64'(out_valid), 64'd1);
    drain();

    // subnormal latency: s=1 needs 23 shifts, 7FFFFF needs one
    send_exp(32'h00000001, 64'h36A0000000000000, 64'h36A0000000000000, 1'b0);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) nb++;
    end
    chk("sub1_busy_cycles", 64'(nb), 64'd23);
    drain();
    send_exp(32'h007FFFFF, 64'h380FFFFFC0000000, 64'h380FFFFFC0000000, 1'b0);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) nb++;
    end
    chk("sub_max_busy_cycles", 64'(nb), 64'd1);
    drain();

    // specials
    send_exp(32'h7F800001, 64'h7FF8000000000000, 64'h7FF8000020000000, 1'b1);
    send_exp(32'hFFC00000, 64'h7FF8000000000000, 64'hFFF8000000000000, 1'b0);
    send_exp(32'hFF800000, 64'hFFF0000000000000, 64'hFFF0000000000000, 1'b0);
    send_exp(32'h80000000, 64'h8000000000000000, 64'h8000000000000000, 1'b0);
    send_exp(32'h7F7FFFFF, 64'h47EFFFFFE0000000, 64'h47EFFFFFE0000000, 1'b0);
    drain();

    // backpressure hold
    rdy_mode = 0;
    @(posedge clk); #2;
    send_exp(32'h3F800000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_d", d, 64'h3FF0000000000000);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;

    // back-to-back stream of 8 normals
    rdy_mode = 1;
    first_acc = 0;
    for (int i = 0; i < 8; i++) begin
      x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      send(x);
      if (i == 0) first_acc = acc_cyc;
    end
    chk("stream_accept_span", 64'(acc_cyc - first_acc), 64'd7);
    drain();
    chk("stream_output_span", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-8]), 64'd7);

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic        sg;
      logic [7:0]  es;
      logic [22:0] fs;
      sg = 1'($urandom_range(0, 1));
      fs = 23'($urandom);
      case ($urandom_range(0, 5))
        0: es = 8'($urandom_range(1, 254));
        1: begin
             es = 8'h00;
             if ($urandom_range(0, 1) == 1) fs = 23'd1 << $urandom_range(0, 22);
             if (fs == 23'd0) fs = 23'd1;
           end
        2: begin es = 8'h00; fs = 23'd0; end
        3: begin es = 8'hFF; fs = 23'd0; end
        4: begin es = 8'hFF; if (fs == 23'd0) fs = 23'd5; end
        default: es = 8'($urandom);
      endcase
      send({sg, es, fs});
    end
    rdy_mode = 1;
    drain();

    // reset in the 10th cycle of a normalisation
    send(32'h00000001);
    repeat (9) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_d", d, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_nv", 64'(nv), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("postrst_quiet", 64'(out_valid), 64'd0);
    end
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send_exp(32'h40490FDB, 64'h400921FB60000000, 64'h400921FB60000000, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
